// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, instruction
// word geometry and default address/offset widths.
package fetch_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPC_HI    = 15;
  localparam int OPC_LO    = 13;
  localparam int PC_W_DEF  = 3;
  localparam int OFF_W_DEF = 7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Extract the opcode field of an instruction word.
  function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC helper: redirect target selection (jump over branch),
// sequential increment and wrap detection.
module next_pc_logic
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [PC_W-1:0]  pc_q,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [PC_W-1:0]  branch_base,
  input  logic [OFF_W-1:0] branch_offset,
  output logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc_inc,
  output logic             wrap
);

  // Sum width always exceeds PC_W so the truncation slice below is never empty.
  localparam int SW = PC_W + OFF_W;

  logic [SW-1:0] base_ext;
  logic [SW-1:0] off_ext;
  logic [SW-1:0] branch_sum;
  logic          unused_sum_hi;

  assign base_ext   = SW'(branch_base);
  assign off_ext    = SW'($signed(branch_offset));
  assign branch_sum = base_ext + SW'(1) + off_ext;

  // Only the low PC_W bits matter: the target wraps modulo the address space.
  assign unused_sum_hi = &{1'b0, branch_sum[SW-1:PC_W]};

  // Jump wins over branch when both are asserted.
  always_comb begin
    target = jump_en ? jump_target : branch_sum[PC_W-1:0];
  end

  assign pc_inc = pc_q + PC_W'(1);
  assign wrap   = &pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the word returned at pc into a
// one-entry valid/ready output register, applies jump/branch redirects, counts
// fetches and supports a drain-then-halt stop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int OFF_W    = OFF_W_DEF,
  parameter int CNT_W    = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_base,
  input  logic [OFF_W-1:0]   branch_offset,
  input  logic               halt_req,
  output logic               halted,
  output logic               pc_wrap,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            wrap;
  logic            redirect;
  logic            advance;

  next_pc_logic #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_pc (
    .pc_q          (pc_q),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .target        (target),
    .pc_inc        (pc_inc),
    .wrap          (wrap)
  );

  // Redirects are dead once halted; fetching only happens in RUN with room downstream.
  assign redirect = (jump_en || branch_taken) && (state != HALTED);
  assign advance  = (state == RUN) && (!out_valid || out_ready);

  assign pc     = pc_q;
  assign halted = (state == HALTED);

  // PC, output register, wrap pulse, fetch counter and RUN/DRAIN/HALTED FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= PC_W'(RESET_PC);
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      pc_wrap     <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc_wrap <= 1'b0;

      if (redirect) begin
        // Flush both the held word and the word being fetched this cycle.
        pc_q      <= target;
        out_valid <= 1'b0;
      end else if (advance) begin
        out_instr <= instr_in;
        out_pc    <= pc_q;
        out_valid <= 1'b1;
        pc_q      <= pc_inc;
        pc_wrap   <= wrap;
        if (fetch_count != '1) begin
          fetch_count <= fetch_count + CNT_W'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // State transitions look at the output register as it was this cycle.
      case (state)
        RUN: begin
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid || out_ready || redirect) state <= HALTED;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
